// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between I-cache and D-cache with arbitration and a response watchdog
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 128,
  parameter int PRIO_MODE   = 0,
  parameter int STARVE_LIM  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic [LINE_W-1:0] ic_res_data,
  output logic              ic_res_ready,
  input  logic              dc_req_valid,
  input  logic              dc_req_rw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [LINE_W-1:0] dc_req_data,
  output logic [LINE_W-1:0] dc_res_data,
  output logic              dc_res_ready,
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_data,
  input  logic              mem_res_ready,
  input  logic [LINE_W-1:0] mem_res_data,
  output logic [1:0]        owner,
  output logic              timeout_err,
  output logic [7:0]        err_count
);
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic last_ic_q, last_ic_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] timer_q, timer_d;
  logic mv_q, mv_d, rw_q, rw_d, icr_q, icr_d, dcr_q, dcr_d, to_q, to_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d, icd_q, icd_d, dcd_q, dcd_d;
  logic [1:0] owner_q, owner_d;
  logic [7:0] ec_q, ec_d;
  logic grant_ic;
  assign grant_ic = ic_req_valid && (!dc_req_valid ||
                    (PRIO_MODE == 0 ? !last_ic_q : starve_q == SW'(STARVE_LIM)));
  assign ic_res_data   = icd_q;
  assign ic_res_ready  = icr_q;
  assign dc_res_data   = dcd_q;
  assign dc_res_ready  = dcr_q;
  assign mem_req_valid = mv_q;
  assign mem_req_rw    = rw_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_data  = wdata_q;
  assign owner         = owner_q;
  assign timeout_err   = to_q;
  assign err_count     = ec_q;
  // grant in IDLE, await memory or watchdog in WAIT, pulse the response in DONE
  always_comb begin
    state_d   = state_q;
    last_ic_d = last_ic_q;
    starve_d  = starve_q;
    timer_d   = timer_q;
    mv_d      = mv_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    icd_d     = icd_q;
    dcd_d     = dcd_q;
    owner_d   = owner_q;
    ec_d      = ec_q;
    icr_d     = 1'b0;
    dcr_d     = 1'b0;
    to_d      = 1'b0;
    case (state_q)
      IDLE: if (ic_req_valid || dc_req_valid) begin
        state_d   = WAIT;
        mv_d      = 1'b1;
        timer_d   = '0;
        last_ic_d = grant_ic;
        owner_d   = grant_ic ? 2'b01 : 2'b10;
        rw_d      = !grant_ic && dc_req_rw;
        addr_d    = grant_ic ? ic_req_addr : dc_req_addr;
        wdata_d   = grant_ic ? {LINE_W{1'b0}} : dc_req_data;
        starve_d  = grant_ic ? '0 : (PRIO_MODE == 1 && ic_req_valid) ? starve_q + 1'b1 : starve_q;
      end
      WAIT: if (mem_res_ready) begin
        state_d = DONE;
        mv_d    = 1'b0;
        icr_d   = owner_q[0];
        dcr_d   = !owner_q[0];
        icd_d   = owner_q[0] ? mem_res_data : icd_q;
        dcd_d   = owner_q[0] ? dcd_q : mem_res_data;
      end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = IDLE;
        mv_d    = 1'b0;
        to_d    = 1'b1;
        owner_d = 2'b00;
        ec_d    = ec_q + 8'(ec_q != 8'hFF);
      end else begin
        timer_d = timer_q + 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        owner_d = 2'b00;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_ic_q <= 1'b1;
      starve_q  <= '0;
      timer_q   <= '0;
      mv_q      <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      icd_q     <= '0;
      dcd_q     <= '0;
      owner_q   <= 2'b00;
      ec_q      <= 8'd0;
      icr_q     <= 1'b0;
      dcr_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_ic_q <= last_ic_d;
      starve_q  <= starve_d;
      timer_q   <= timer_d;
      mv_q      <= mv_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      icd_q     <= icd_d;
      dcd_q     <= dcd_d;
      owner_q   <= owner_d;
      ec_q      <= ec_d;
      icr_q     <= icr_d;
      dcr_q     <= dcr_d;
      to_q      <= to_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized transaction-level bench for a round-robin and a D-priority arbiter
module tb_mem_arbiter;
  localparam int TO = 8, LIM = 4;
  logic clk = 0, rst;
  always #5 clk = ~clk;
  logic ic_v[2], dc_v[2], dc_rw[2], mrr[2];
  logic [31:0] ic_a[2], dc_a[2];
  logic [127:0] dc_d[2], mrd[2];
  logic [127:0] ic_rd_o[2], dc_rd_o[2], md_o[2];
  logic ic_rr_o[2], dc_rr_o[2], mv_o[2], mrw_o[2], to_o[2];
  logic [31:0] ma_o[2];
  logic [1:0] own_o[2];
  logic [7:0] ec_o[2];
  logic e_mv[2], e_rw[2], e_icr[2], e_dcr[2], e_to[2];
  logic [31:0] e_addr[2];
  logic [127:0] e_data[2], e_icd[2], e_dcd[2];
  logic [1:0] e_own[2];
  int e_err[2];
  logic m_last_ic[2];
  int m_starve[2];
  int n_chk = 0, n_err = 0;
  logic cmp_en = 0, pin_en = 0;
  int pin_k, pin_sel;
  string pin_nm;
  logic [127:0] pin_mask, pin_val;
  logic [31:0] glog[2];
  logic mv_prev[2];

  for (genvar g = 0; g < 2; g++) begin : dut
    mem_arbiter #(.ADDR_W(32), .LINE_W(128), .PRIO_MODE(g), .STARVE_LIM(LIM), .TIMEOUT_CYC(TO)) u (
      .clk(clk), .rst(rst),
      .ic_req_valid(ic_v[g]), .ic_req_addr(ic_a[g]),
      .ic_res_data(ic_rd_o[g]), .ic_res_ready(ic_rr_o[g]),
      .dc_req_valid(dc_v[g]), .dc_req_rw(dc_rw[g]), .dc_req_addr(dc_a[g]), .dc_req_data(dc_d[g]),
      .dc_res_data(dc_rd_o[g]), .dc_res_ready(dc_rr_o[g]),
      .mem_req_valid(mv_o[g]), .mem_req_rw(mrw_o[g]), .mem_req_addr(ma_o[g]), .mem_req_data(md_o[g]),
      .mem_res_ready(mrr[g]), .mem_res_data(mrd[g]),
      .owner(own_o[g]), .timeout_err(to_o[g]), .err_count(ec_o[g])
    );
  end

  task automatic chk(input string nm, input int k, input logic [127:0] a, input logic [127:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s dut%0d @%0t got %h want %h", nm, k, $time, a, e);
    end
  endtask

  // single compare process: every output of both arbiters against the model, plus literal pins
  initial begin
    logic [127:0] a;
    glog[0] = 0; glog[1] = 0; mv_prev[0] = 0; mv_prev[1] = 0;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int k = 0; k < 2; k++) begin
          if (mv_o[k] === 1'b1 && !mv_prev[k]) glog[k] = {glog[k][29:0], own_o[k]};
          mv_prev[k] = (mv_o[k] === 1'b1);
          chk("mem_req_valid", k, 128'(mv_o[k]), 128'(e_mv[k]));
          chk("owner", k, 128'(own_o[k]), 128'(e_own[k]));
          chk("ic_res_ready", k, 128'(ic_rr_o[k]), 128'(e_icr[k]));
          chk("dc_res_ready", k, 128'(dc_rr_o[k]), 128'(e_dcr[k]));
          chk("ic_res_data", k, ic_rd_o[k], e_icd[k]);
          chk("dc_res_data", k, dc_rd_o[k], e_dcd[k]);
          chk("timeout_err", k, 128'(to_o[k]), 128'(e_to[k]));
          chk("err_count", k, 128'(ec_o[k]), 128'(e_err[k]));
          if (e_mv[k]) begin
            chk("mem_req_rw", k, 128'(mrw_o[k]), 128'(e_rw[k]));
            chk("mem_req_addr", k, 128'(ma_o[k]), 128'(e_addr[k]));
            chk("mem_req_data", k, md_o[k], e_data[k]);
          end
        end
        if (pin_en) begin
          case (pin_sel)
            0: a = ic_rd_o[pin_k];
            1: a = dc_rd_o[pin_k];
            2: a = 128'(ec_o[pin_k]);
            3: a = 128'(glog[pin_k]);
            default: a = 128'({mv_o[pin_k], own_o[pin_k], ic_rr_o[pin_k], dc_rr_o[pin_k], to_o[pin_k]});
          endcase
          chk(pin_nm, pin_k, a & pin_mask, pin_val);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string nm, input int k, input int sel, input logic [127:0] mask, input logic [127:0] val);
    pin_nm = nm; pin_k = k; pin_sel = sel; pin_mask = mask; pin_val = val; pin_en = 1;
    @(negedge clk);
    #1;
    pin_en = 0;
  endtask

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      e_mv[k] = 0; e_rw[k] = 0; e_icr[k] = 0; e_dcr[k] = 0; e_to[k] = 0;
      e_addr[k] = 0; e_data[k] = 0; e_icd[k] = 0; e_dcd[k] = 0; e_own[k] = 0; e_err[k] = 0;
      m_last_ic[k] = 1; m_starve[k] = 0;
    end
  endtask

  // winner from the arbitration rules: k is also the priority mode of arbiter k
  task automatic arb(input int k, output int w);
    logic both;
    both = ic_v[k] && dc_v[k];
    if (both) w = (k == 0) ? (m_last_ic[k] ? 2 : 1) : (m_starve[k] == LIM ? 1 : 2);
    else w = ic_v[k] ? 1 : 2;
    if (w == 1) m_starve[k] = 0;
    else if (both && k == 1) m_starve[k]++;
    m_last_ic[k] = (w == 1);
  endtask

  task automatic grant(input int k, input int w);
    e_mv[k] = 1; e_own[k] = 2'(w); e_to[k] = 0;
    e_rw[k] = (w == 2) ? dc_rw[k] : 1'b0;
    e_addr[k] = (w == 1) ? ic_a[k] : dc_a[k];
    e_data[k] = (w == 1) ? 128'd0 : dc_d[k];
  endtask

  task automatic new_dc(input int k);
    dc_v[k] = 1; dc_rw[k] = 1'($urandom_range(1)); dc_a[k] = $urandom;
    dc_d[k] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // issue n_ic/n_dc requests (re-requesting after each completion); first n_to grants time out
  task automatic run(input int k, input int n_ic, input int n_dc, input int n_to, input int to_pct,
                     input int fd, input logic [127:0] fdat);
    int il, dl, tl, w, d;
    il = n_ic; dl = n_dc; tl = n_to;
    if (il > 0) begin ic_v[k] = 1; ic_a[k] = (fd > 0) ? 32'h40 : $urandom; end
    if (dl > 0) new_dc(k);
    while (ic_v[k] || dc_v[k]) begin
      arb(k, w);
      step();
      grant(k, w);
      if (fd > 0) d = fd;
      else if (tl > 0 || $urandom_range(99) < to_pct) d = TO + 1;
      else d = $urandom_range(1, TO);
      if (tl > 0) tl--;
      for (int j = 1; j <= TO; j++) begin
        mrr[k] = (j == d);
        mrd[k] = (fd > 0 && j == d) ? fdat : {$urandom, $urandom, $urandom, $urandom};
        step();
        if (j == d) begin
          e_mv[k] = 0;
          if (w == 1) begin e_icr[k] = 1; e_icd[k] = mrd[k]; end
          else begin e_dcr[k] = 1; e_dcd[k] = mrd[k]; end
          break;
        end
        if (j == TO) begin
          e_mv[k] = 0; e_to[k] = 1; e_own[k] = 0;
          e_err[k] = (e_err[k] < 255) ? e_err[k] + 1 : 255;
        end
      end
      mrr[k] = 1'($urandom_range(1));
      mrd[k] = {$urandom, $urandom, $urandom, $urandom};
      if (d <= TO) begin
        if (w == 1) begin ic_v[k] = 0; il--; end
        else begin dc_v[k] = 0; dl--; end
        step();
        e_icr[k] = 0; e_dcr[k] = 0; e_own[k] = 0;
        if (w == 1 && il > 0) begin ic_v[k] = 1; ic_a[k] = $urandom; end
        if (w == 2 && dl > 0) new_dc(k);
      end
    end
    mrr[k] = 0;
    step();
  endtask

  initial begin
    int w;
    rst = 0;
    for (int k = 0; k < 2; k++) begin
      ic_v[k] = 1; dc_v[k] = 1; dc_rw[k] = 0; mrr[k] = 0;
      ic_a[k] = 0; dc_a[k] = 0; dc_d[k] = 0; mrd[k] = 0;
    end
    mreset();
    step();
    cmp_en = 1;
    step();
    step();
    pin("rst_flags", 0, 4, '1, 0);
    pin("rst_flags", 1, 4, '1, 0);
    pin("rst_err", 1, 2, '1, 0);
    rst = 1;
    for (int k = 0; k < 2; k++) begin ic_v[k] = 0; dc_v[k] = 0; end
    step();
    run(0, 1, 0, 0, 0, 5, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
    pin("ic_fill", 0, 0, '1, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
    pin("dc_untouched", 0, 1, '1, 0);
    pin("ic_grant", 0, 3, 128'h3, 128'h1);
    run(0, 2, 2, 0, 0, 0, 0);
    pin("rr_seq", 0, 3, 128'hFF, 128'h99);
    run(1, 2, 8, 0, 0, 0, 0);
    pin("prio_seq", 1, 3, 128'hFFFFF, 128'hAA6A9);
    run(0, 1, 0, 1, 0, 0, 0);
    pin("err_one", 0, 2, '1, 1);
    run(0, 0, 1, 300, 0, 0, 0);
    pin("err_sat", 0, 2, '1, 255);
    repeat (6)
      for (int k = 0; k < 2; k++) run(k, $urandom_range(0, 5), $urandom_range(1, 5), 0, 15, 0, 0);
    dc_v[1] = 1; dc_rw[1] = 1; dc_a[1] = $urandom; dc_d[1] = {$urandom, $urandom, $urandom, $urandom};
    arb(1, w);
    step();
    grant(1, w);
    step();
    step();
    rst = 0;
    step();
    mreset();
    rst = 1;
    dc_v[1] = 0;
    step();
    step();
    pin("abort_flags", 1, 4, '1, 0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
